// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU/MDU.
// Any 6-bit code not listed here is undefined: result 0, no branch, one-cycle latency.
package alu_pkg;

    localparam logic [5:0] OP_ADD    = 6'b000000;
    localparam logic [5:0] OP_SUB    = 6'b010000;
    localparam logic [5:0] OP_SLL    = 6'b000001;
    localparam logic [5:0] OP_SLT    = 6'b000010;
    localparam logic [5:0] OP_SLTU   = 6'b000011;
    localparam logic [5:0] OP_XOR    = 6'b000100;
    localparam logic [5:0] OP_SRL    = 6'b000101;
    localparam logic [5:0] OP_SRA    = 6'b010101;
    localparam logic [5:0] OP_OR     = 6'b000110;
    localparam logic [5:0] OP_AND    = 6'b000111;

    localparam logic [5:0] OP_MUL    = 6'b001000;
    localparam logic [5:0] OP_MULH   = 6'b001001;
    localparam logic [5:0] OP_MULHSU = 6'b001010;
    localparam logic [5:0] OP_MULHU  = 6'b001011;
    localparam logic [5:0] OP_DIV    = 6'b001100;
    localparam logic [5:0] OP_DIVU   = 6'b001101;
    localparam logic [5:0] OP_REM    = 6'b001110;
    localparam logic [5:0] OP_REMU   = 6'b001111;

    localparam logic [5:0] OP_BEQ    = 6'b100000;
    localparam logic [5:0] OP_BNE    = 6'b100001;
    localparam logic [5:0] OP_BLT    = 6'b100100;
    localparam logic [5:0] OP_BGE    = 6'b100101;
    localparam logic [5:0] OP_BLTU   = 6'b100110;
    localparam logic [5:0] OP_BGEU   = 6'b100111;

    // M-op selector as seen by the iterative unit (low three opcode bits)
    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative sign-magnitude multiplier / restoring divider, one bit per cycle.
// First iteration runs on the start edge; done is high XLEN cycles later for one cycle; no stall input.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import alu_pkg::*;

    localparam int CW = $clog2(XLEN) + 1;

    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_a;

    logic            w_s1, w_s2, w_n1, w_n2;
    logic [XLEN-1:0] w_abs1, w_abs2, w_a0, w_lo0;
    logic [XLEN-1:0] w_hi, w_lo, w_a;
    logic            w_div;
    logic [XLEN:0]   w_sum, w_trial;
    logic            w_ge;
    logic [XLEN-1:0] w_n_hi, w_n_lo;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0] w_quo, w_rem;

    assign w_s1   = (op == M_MULH) | (op == M_MULHSU) | (op == M_DIV) | (op == M_REM);
    assign w_s2   = (op == M_MULH) | (op == M_DIV) | (op == M_REM);
    assign w_n1   = w_s1 & rs1[XLEN-1];
    assign w_n2   = w_s2 & rs2[XLEN-1];
    assign w_abs1 = w_n1 ? -rs1 : rs1;
    assign w_abs2 = w_n2 ? -rs2 : rs2;
    // Multiply: r_a = multiplicand, r_lo = multiplier. Divide: r_a = divisor, r_lo = dividend.
    assign w_a0   = op[2] ? w_abs2 : w_abs1;
    assign w_lo0  = op[2] ? w_abs1 : w_abs2;

    assign w_hi   = start ? '0    : r_hi;
    assign w_lo   = start ? w_lo0 : r_lo;
    assign w_a    = start ? w_a0  : r_a;
    assign w_div  = start ? op[2] : r_op[2];

    assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_a} : '0);
    assign w_trial = {w_hi, w_lo[XLEN-1]} - {1'b0, w_a};
    assign w_ge    = ~w_trial[XLEN];

    assign w_n_hi = w_div ? (w_ge ? w_trial[XLEN-1:0] : {w_hi[XLEN-2:0], w_lo[XLEN-1]})
                          : w_sum[XLEN:1];
    assign w_n_lo = w_div ? {w_lo[XLEN-2:0], w_ge}
                          : {w_sum[0], w_lo[XLEN-1:1]};

    assign done = r_busy && (r_cnt == CW'(XLEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
        end else if (kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(1);
            r_op    <= op;
            r_neg_q <= w_n1 ^ w_n2;
            r_neg_r <= w_n1;
            r_a     <= w_a0;
            r_hi    <= w_n_hi;
            r_lo    <= w_n_lo;
        end else if (r_busy) begin
            if (done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                r_hi  <= w_n_hi;
                r_lo  <= w_n_lo;
            end
        end
    end

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_lo : r_lo;
    assign w_rem    = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        result = '0;
        case (r_op)
            M_MUL:                     result = w_prod_s[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: result = w_prod_s[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:             result = w_quo;
            default:                   result = w_rem;
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// Single-issue ALU + iterative MUL/DIV with valid/ready on both sides.
// Latency 1 for base/branch/divide-special ops, XLEN+1 for M-ops; result held in DONE until out_ready.
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_ctr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            out_cmp
);
    import alu_pkg::*;

    state_t          r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_res;
    logic            r_out_cmp;

    logic            w_accept, w_is_m, w_div0, w_ovf, w_fast;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_res;
    logic            w_cmp;
    logic            w_mdu_done;
    logic [XLEN-1:0] w_mdu_res;

    assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_cmp   = r_out_cmp;

    assign w_accept = in_valid & in_ready & ~flush;
    assign w_is_m   = (in_ctr[5:3] == 3'b001);
    assign w_div0   = (in_rs2 == '0);
    assign w_ovf    = ~in_ctr[0] & (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&in_rs2);
    // Divide by zero and signed overflow bypass the iterative unit entirely
    assign w_fast   = ~w_is_m | (in_ctr[2] & (w_div0 | w_ovf));
    assign w_shamt  = in_rs2[SHW-1:0];

    always_comb begin
        w_res = '0;
        w_cmp = 1'b0;
        case (in_ctr)
            OP_ADD:  w_res = in_rs1 + in_rs2;
            OP_SUB:  w_res = in_rs1 - in_rs2;
            OP_SLL:  w_res = in_rs1 << w_shamt;
            OP_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(in_rs2)};
            OP_SLTU: w_res = {{(XLEN-1){1'b0}}, in_rs1 < in_rs2};
            OP_XOR:  w_res = in_rs1 ^ in_rs2;
            OP_SRL:  w_res = in_rs1 >> w_shamt;
            OP_SRA:  w_res = $signed(in_rs1) >>> w_shamt;
            OP_OR:   w_res = in_rs1 | in_rs2;
            OP_AND:  w_res = in_rs1 & in_rs2;
            OP_DIV, OP_DIVU: w_res = w_div0 ? '1 : in_rs1;
            OP_REM, OP_REMU: w_res = w_div0 ? in_rs1 : '0;
            OP_BEQ:  w_cmp = (in_rs1 == in_rs2);
            OP_BNE:  w_cmp = (in_rs1 != in_rs2);
            OP_BLT:  w_cmp = ($signed(in_rs1) < $signed(in_rs2));
            OP_BGE:  w_cmp = ($signed(in_rs1) >= $signed(in_rs2));
            OP_BLTU: w_cmp = (in_rs1 < in_rs2);
            OP_BGEU: w_cmp = (in_rs1 >= in_rs2);
            default: ;
        endcase
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .start  (w_accept & ~w_fast),
        .op     (in_ctr[2:0]),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .done   (w_mdu_done),
        .result (w_mdu_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_cmp   <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_MUL, ST_DIV: begin
                    if (w_mdu_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_res   <= w_mdu_res;
                        r_out_cmp   <= 1'b0;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_fast) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_out_res   <= w_res;
                            r_out_cmp   <= w_cmp;
                        end else begin
                            r_state     <= in_ctr[2] ? ST_DIV : ST_MUL;
                            r_out_valid <= 1'b0;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at XLEN=32 and XLEN=64 with hand-computed expected results.
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic        v32, rdy32, ordy32, ov32, oc32;
    logic [5:0]  c32;
    logic [31:0] a32, b32, r32;
    logic        v64, rdy64, ordy64, ov64, oc64;
    logic [5:0]  c64;
    logic [63:0] a64, b64, r64;

    int n_chk  = 0;
    int n_fail = 0;

    alu_mdu #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(v32), .in_ready(rdy32), .in_ctr(c32), .in_rs1(a32), .in_rs2(b32),
        .out_valid(ov32), .out_ready(ordy32), .out_res(r32), .out_cmp(oc32)
    );

    alu_mdu #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(v64), .in_ready(rdy64), .in_ctr(c64), .in_rs1(a64), .in_rs2(b64),
        .out_valid(ov64), .out_ready(ordy64), .out_res(r64), .out_cmp(oc64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op32(input string tag, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_cmp, input int exp_lat);
        int lat;
        v32 = 1'b1; c32 = c; a32 = a; b32 = b;
        step();
        v32 = 1'b0; a32 = $urandom; b32 = $urandom;
        lat = 1;
        while (!ov32 && lat < 200) begin
            step();
            lat++;
        end
        check({tag, "_res"}, r32, exp_res);
        check({tag, "_cmp"}, oc32, exp_cmp);
        check({tag, "_lat"}, lat, exp_lat);
        ordy32 = 1'b1;
        step();
        ordy32 = 1'b0;
    endtask

    task automatic op64(input string tag, input logic [5:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
        int lat;
        v64 = 1'b1; c64 = c; a64 = a; b64 = b;
        step();
        v64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        lat = 1;
        while (!ov64 && lat < 200) begin
            step();
            lat++;
        end
        check({tag, "_res"}, r64, exp_res);
        check({tag, "_lat"}, lat, exp_lat);
        ordy64 = 1'b1;
        step();
        ordy64 = 1'b0;
    endtask

    initial begin
        logic seen;
        v32 = 0; c32 = 0; a32 = 0; b32 = 0; ordy32 = 0;
        v64 = 0; c64 = 0; a64 = 0; b64 = 0; ordy64 = 0;
        repeat (3) step();
        check("rst_out32", {ov32, oc32, r32}, 0);
        check("rst_out64", {ov64, oc64, r64[62:0]}, 0);
        rst = 1'b0;
        step();
        check("rst_rdy32", rdy32, 1);

        // back-to-back base ops with out_ready held high
        ordy32 = 1'b1; v32 = 1'b1; c32 = OP_ADD; a32 = 32'h7FFFFFFF; b32 = 32'h1;
        step();
        check("add_vld", ov32, 1);
        check("add_res", r32, 32'h80000000);
        check("b2b_rdy", rdy32, 1);
        c32 = OP_SUB; a32 = 32'd5; b32 = 32'd7;
        step();
        v32 = 1'b0;
        check("sub_vld", ov32, 1);
        check("sub_res", r32, 32'hFFFFFFFE);
        step();
        check("b2b_idle", ov32, 0);
        ordy32 = 1'b0;

        op32("mulh",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0, 33);
        op32("mulhu",  OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 0, 33);
        op32("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 0, 33);
        op32("mul",    OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 33);
        op32("div",    OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 0, 33);
        op32("rem",    OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 0, 33);
        op32("div_np", OP_DIV,    32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 33);
        op32("rem_np", OP_REM,    32'h7,        32'hFFFFFFFE, 32'h00000001, 0, 33);
        op32("divu",   OP_DIVU,   32'd100,      32'd7,        32'd14,       0, 33);
        op32("remu",   OP_REMU,   32'd100,      32'd7,        32'd2,        0, 33);
        op32("divu0",  OP_DIVU,   32'h7,        32'h0,        32'hFFFFFFFF, 0, 1);
        op32("remu0",  OP_REMU,   32'h7,        32'h0,        32'h7,        0, 1);
        op32("rem_ov", OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 1);
        op32("div_ov", OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1);
        op32("sra",    OP_SRA,    32'h80000000, 32'h21,       32'hC0000000, 0, 1);
        op32("sll",    OP_SLL,    32'h1,        32'h3F,       32'h80000000, 0, 1);
        op32("srl",    OP_SRL,    32'h80000000, 32'h4,        32'h08000000, 0, 1);
        op32("slt",    OP_SLT,    32'hFFFFFFFF, 32'h1,        32'h1,        0, 1);
        op32("sltu",   OP_SLTU,   32'hFFFFFFFF, 32'h1,        32'h0,        0, 1);
        op32("and",    OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1);
        op32("bgeu",   OP_BGEU,   32'h1,        32'hFFFFFFFF, 32'h0,        0, 1);
        op32("blt",    OP_BLT,    32'hFFFFFFFF, 32'h1,        32'h0,        1, 1);
        op32("bltu",   OP_BLTU,   32'h1,        32'hFFFFFFFF, 32'h0,        1, 1);
        op32("beq",    OP_BEQ,    32'h3,        32'h3,        32'h0,        1, 1);
        op32("bne",    OP_BNE,    32'h3,        32'h3,        32'h0,        0, 1);
        op32("undef_b", 6'b100010, 32'h5,       32'h5,        32'h0,        0, 1);
        op32("undef_m", 6'b011000, 32'h5,       32'h5,        32'h0,        0, 1);

        // flush mid-divide, with a competing request in the same cycle
        v32 = 1'b1; c32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7;
        step();
        v32 = 1'b0;
        repeat (8) step();
        flush = 1'b1; v32 = 1'b1; c32 = OP_ADD; a32 = 1; b32 = 1;
        step();
        flush = 1'b0; v32 = 1'b0;
        check("flush_vld", ov32, 0);
        check("flush_rdy", rdy32, 1);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (ov32) seen = 1'b1;
        end
        check("flush_quiet", seen, 0);

        // flush beats accept while idle
        flush = 1'b1; v32 = 1'b1; c32 = OP_ADD; a32 = 2; b32 = 2;
        step();
        flush = 1'b0; v32 = 1'b0;
        step();
        check("flush_acc", ov32, 0);

        // reset mid-divide
        v32 = 1'b1; c32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7;
        step();
        v32 = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_vld", ov32, 0);
        check("rst_mid_rdy", rdy32, 1);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (ov32) seen = 1'b1;
        end
        check("rst_quiet", seen, 0);

        // consumer stall in DONE while the operands change underneath
        v32 = 1'b1; c32 = OP_ADD; a32 = 32'd3; b32 = 32'd4;
        step();
        v32 = 1'b0; a32 = 32'hDEAD; b32 = 32'hBEEF;
        for (int i = 0; i < 5; i++) begin
            check("stall", {ov32, rdy32, r32}, {1'b1, 1'b0, 32'd7});
            step();
        end
        ordy32 = 1'b1;
        step();
        ordy32 = 1'b0;
        check("stall_rel", ov32, 0);

        op64("mulh64",   OP_MULH,   64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 65);
        op64("mulhu64",  OP_MULHU,  64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 65);
        op64("mulhsu64", OP_MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'h2,                64'hFFFFFFFFFFFFFFFF, 65);
        op64("mul64",    OP_MUL,    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h1,                65);
        op64("div64",    OP_DIV,    64'hFFFFFFFFFFFFFFF9, 64'h2,                64'hFFFFFFFFFFFFFFFD, 65);
        op64("rem64",    OP_REM,    64'hFFFFFFFFFFFFFFF9, 64'h2,                64'hFFFFFFFFFFFFFFFF, 65);
        op64("divu0_64", OP_DIVU,   64'h7,                64'h0,                64'hFFFFFFFFFFFFFFFF, 1);
        op64("remov64",  OP_REM,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1);
        op64("divov64",  OP_DIV,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (32 or 64).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width, derived, not overridden.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  kill any in-flight or pending result.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted when in_valid & in_ready.
REQ-008 in_ctr  input  6  operation code (REQ-014).
REQ-009 in_rs1, in_rs2  input  XLEN  operands.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result when out_valid & out_ready.
REQ-012 out_res  output  XLEN  arithmetic/logic result; 0 for branch codes.
REQ-013 out_cmp  output  1  branch-taken flag; 0 for non-branch codes.

Function
REQ-014 SHALL decode in_ctr: bit5=1 branch (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111 in bits2:0); bit5=0,bit3=0 base ops (ADD/SUB 000 with bit4 select, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101 with bit4 select, OR 110, AND 111); bit5=0,bit3=1 M-ops in bits2:0 (MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111).
REQ-015 SHALL treat any undefined code as a base op with out_res=0, out_cmp=0, latency 1.
REQ-016 SHALL use only in_rs2[SHW-1:0] as shift amount; SRA sign-fills.
REQ-017 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-018 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; 0 in MUL/DIV.
REQ-019 Base/branch/undefined ops SHALL go to DONE with registered result one cycle after accept.
REQ-020 M-ops SHALL be iterative, one bit per cycle: MUL state / DIV state for exactly XLEN cycles, then DONE; out_valid first high XLEN+1 cycles after accept.
REQ-021 MUL SHALL return low XLEN bits; MULH/MULHSU/MULHU upper XLEN bits of 2*XLEN product with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-022 Signed DIV/REM SHALL truncate toward zero; REM takes sign of dividend.
REQ-023 Divisor zero: quotient all-ones, remainder = rs1; resolved at accept, DONE next cycle (latency 1).
REQ-024 Signed overflow (rs1 = most-negative, rs2 = -1): DIV = rs1, REM = 0; latency 1.
REQ-025 DONE SHALL hold out_valid, out_res, out_cmp stable until out_ready; then go IDLE, or accept a new request in the same cycle (back-to-back, one base op per cycle).
REQ-026 flush SHALL force IDLE next cycle, out_valid=0, and discard any in_valid in the same cycle; flush beats accept and out_ready.
REQ-027 Operands SHALL be captured at accept; later in_rs1/in_rs2 changes SHALL not affect the result.

Reset
REQ-028 On rst: state IDLE, out_valid 0, out_res 0, out_cmp 0, iteration counter 0; in_ready 1 once rst deasserts.
REQ-029 rst mid-operation SHALL abandon the operation with no result ever presented.

Structure
REQ-030 Opcode constants (all 6-bit codes of REQ-014) and state encoding SHALL live in shared package alu_pkg, reused by decoder and alu_mdu.
REQ-031 Iterative multiply/divide datapath SHALL be one sub-module, mdu_iter (start, op, operands in; done, result out); base ops stay in alu_mdu.

Verification
REQ-032 ADD 0x7FFFFFFF + 1, out_ready=1 -> out_valid next cycle, out_res 0x80000000; back-to-back SUB 5-7 next cycle -> 0xFFFFFFFE one cycle later.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000 after 33 cycles; MULHU same -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF; MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
REQ-034 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF in 1 cycle; REM 0x80000000/-1 -> 0, DIV same -> 0x80000000.
REQ-035 SRA 0x80000000 by in_rs2=0x21 -> shift 1, 0xC0000000; BGEU 1,0xFFFFFFFF -> out_cmp 0, out_res 0.
REQ-036 DIVU started, flush at cycle 10 -> no out_valid, in_ready 1 next cycle; repeat with rst at cycle 10 -> same.
REQ-037 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0; XLEN=64 rerun of REQ-033/034 with 65-cycle latency.
